multicycle_rv_core: RTL
=======================

MULTICYCLE_RV_CORE -- requirements
Module: multicycle_rv_core

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and register width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, PC and instruction-address width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset; word-aligned.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_addr  output  ADDR_WIDTH  fetch byte address, equals PC.
REQ-008 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-010 SHALL have port a0  output  WIDTH  current value of register x10.
REQ-011 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-012 SHALL have port halted  output  1  core stopped.
REQ-013 SHALL have port illegal  output  1  halt caused by illegal or misaligned condition.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-015 SHALL, in FETCH, drive imem_req=1 with imem_addr=PC held stable until imem_ack=1; an ack in the same cycle as req is accepted; capture imem_rdata into IR and go to DECODE.
REQ-016 SHALL ignore imem_ack outside FETCH.
REQ-017 SHALL, in DECODE, read rs1=IR[19:15], rs2=IR[24:20] and form sign-extended I-immediate (IR[31:20]) or B-immediate ({IR[31],IR[7],IR[30:25],IR[11:8],0}) to WIDTH bits.
REQ-018 SHALL, in EXECUTE, compute: ADDI rs1+immI; ADD rs1+rs2; SUB rs1-rs2; BEQ/BNE taken when rs1==rs2 / rs1!=rs2; results wrap modulo 2^WIDTH.
REQ-019 SHALL, in WRITEBACK, write the result to rd=IR[11:7] for ADDI/ADD/SUB, pulse retire=1, update PC, return to FETCH.
REQ-020 SHALL update PC to PC+immB when a branch is taken, else PC+4; PC arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-021 SHALL yield minimum 4 cycles per instruction (ack same cycle as req); each extra wait cycle on imem_ack adds one.
REQ-022 SHALL hardwire x0 to zero; writes to x0 are discarded; reads of x0 return 0.
REQ-023 SHALL decode EBREAK (0x00100073) as: no register write, retire pulse, PC unchanged, enter HALT with illegal=0.
REQ-024 SHALL treat any other opcode/funct3/funct7 combination as illegal: no write, no retire, PC unchanged, enter HALT with illegal=1.
REQ-025 SHALL treat a taken branch whose target has bit 1 set as misaligned: no PC update, no retire, HALT with illegal=1.
REQ-026 SHALL, in HALT, hold imem_req=0, halted=1, all state frozen until reset.
REQ-027 SHALL drive a0 combinationally from x10, so a write to x10 is visible the cycle after WRITEBACK.
REQ-028 SHALL keep retire low in every state except WRITEBACK and the EBREAK HALT transition.

Reset
REQ-029 SHALL, while rst=0, force state FETCH, PC=RESET_PC, IR=0, all registers x1..x31=0, imem_req=0, retire=0, halted=0, illegal=0, a0=0, asynchronously.
REQ-030 SHALL, on reset assertion mid-fetch, drop imem_req immediately and discard any ack in flight.
REQ-031 SHALL assert imem_req in the first rising edge's cycle following rst release (FETCH at RESET_PC).

Verification
REQ-032 Program ADDI x10,x0,5; ADDI x10,x10,-7; EBREAK, ack same cycle -> a0=5 then 0xFFFFFFFE (WIDTH=32), 3 retire pulses, halted=1, illegal=0, 12 cycles total.
REQ-033 ADDI x1,x0,3; ADDI x1,x1,-1; BNE x1,x0,-4; ADD x10,x1,x1; EBREAK -> loop runs 3 times, a0=0, 9 retires, final PC=0x10.
REQ-034 imem_ack delayed 3 cycles each fetch -> imem_addr stable and req held throughout, 7 cycles per instruction, results identical to REQ-032.
REQ-035 ADDI x0,x0,9 then SUB x10,x0,x0 -> x0 remains 0, a0=0; instruction 0xFFFFFFFF -> halted=1, illegal=1, no retire, PC unchanged.
REQ-036 BEQ x0,x0,+6 -> halted=1, illegal=1, PC unchanged; rst pulse low during a stalled fetch -> req drops same cycle, restart at RESET_PC, all registers 0.

Source files
------------

// File: rtl/multicycle_rv_core.sv
// ============================================================================
// Module   : multicycle_rv_core
// Brief    : Multicycle RV subset core (ADDI/ADD/SUB/BEQ/BNE/EBREAK).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_rv_core #(
    parameter int                    WIDTH      = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [WIDTH-1:0]      a0,
    output logic                  retire,
    output logic                  halted,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADDI   = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_BEQ    = 3'd3;
    localparam logic [2:0] OP_BNE    = 3'd4;
    localparam logic [2:0] OP_EBREAK = 3'd5;
    localparam logic [2:0] OP_ILL    = 3'd6;

    state_t                r_state;
    state_t                w_next;
    logic                  r_run;
    logic                  r_illegal;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_next_pc;
    logic [31:0]           r_ir;
    logic [2:0]            r_op;
    logic [WIDTH-1:0]      r_regs [0:31];
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic [WIDTH-1:0]      r_imm;
    logic [WIDTH-1:0]      r_res;

    logic [6:0]            w_opcode;
    logic [6:0]            w_funct7;
    logic [2:0]            w_funct3;
    logic [4:0]            w_rd;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [2:0]            w_op;
    logic [WIDTH-1:0]      w_imm_i;
    logic [WIDTH-1:0]      w_imm_b;
    logic [WIDTH-1:0]      w_alu;
    logic                  w_taken;
    logic                  w_fault;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];
    assign w_imm_i  = {{(WIDTH-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b  = {{(WIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    always_comb begin
        w_op = OP_ILL;
        if (r_ir == 32'h0010_0073) begin
            w_op = OP_EBREAK;
        end else begin
            case (w_opcode)
                7'h13: if (w_funct3 == 3'b000) w_op = OP_ADDI;
                7'h33: begin
                    if (w_funct3 == 3'b000 && w_funct7 == 7'h00)      w_op = OP_ADD;
                    else if (w_funct3 == 3'b000 && w_funct7 == 7'h20) w_op = OP_SUB;
                end
                7'h63: begin
                    if (w_funct3 == 3'b000)      w_op = OP_BEQ;
                    else if (w_funct3 == 3'b001) w_op = OP_BNE;
                end
                default: w_op = OP_ILL;
            endcase
        end
    end

    assign w_taken  = ((r_op == OP_BEQ) && (r_a == r_b)) || ((r_op == OP_BNE) && (r_a != r_b));
    assign w_target = r_pc + r_imm[ADDR_WIDTH-1:0];

    always_comb begin
        case (r_op)
            OP_ADDI: w_alu = r_a + r_imm;
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            default: w_alu = '0;
        endcase
    end

    // Fault = illegal encoding at decode, or taken branch to a half-word target
    always_comb begin
        w_next  = r_state;
        w_fault = 1'b0;
        case (r_state)
            S_FETCH:     if (r_run && imem_ack) w_next = S_DECODE;
            S_DECODE: begin
                if (w_op == OP_ILL) begin
                    w_next  = S_HALT;
                    w_fault = 1'b1;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (w_taken && w_target[1]) begin
                    w_next  = S_HALT;
                    w_fault = 1'b1;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: w_next = (r_op == OP_EBREAK) ? S_HALT : S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_run     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (w_fault) r_illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_next_pc <= RESET_PC;
            r_ir      <= '0;
            r_op      <= OP_ILL;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_res     <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (r_run && imem_ack) r_ir <= imem_rdata;
                S_DECODE: begin
                    r_op  <= w_op;
                    r_a   <= r_regs[w_rs1];
                    r_b   <= r_regs[w_rs2];
                    r_imm <= (w_op == OP_BEQ || w_op == OP_BNE) ? w_imm_b : w_imm_i;
                end
                S_EXECUTE: begin
                    r_res     <= w_alu;
                    r_next_pc <= w_taken ? w_target : r_pc + ADDR_WIDTH'(4);
                end
                S_WRITEBACK: begin
                    // x0 is never written, so its reset value of zero is permanent
                    if ((r_op == OP_ADDI || r_op == OP_ADD || r_op == OP_SUB) && w_rd != 5'd0)
                        r_regs[w_rd] <= r_res;
                    if (r_op != OP_EBREAK) r_pc <= r_next_pc;
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (r_state == S_FETCH) && r_run;
    assign imem_addr = r_pc;
    assign a0        = r_regs[10];
    assign retire    = (r_state == S_WRITEBACK);
    assign halted    = (r_state == S_HALT);
    assign illegal   = r_illegal;

endmodule

`default_nettype wire
